// File: rtl/hdmi_period_scheduler_if.sv
// hdmi_period_scheduler_if: pixel-counter/packet-source inputs and encoder-side outputs of the scheduler
interface hdmi_period_scheduler_if #(parameter int HTOTAL = 800, parameter int VTOTAL = 525);
  logic [$clog2(HTOTAL)-1:0] i_hcount;
  logic [$clog2(VTOTAL)-1:0] i_vcount;
  logic i_island_en;
  logic i_pkt_valid;
  logic o_pkt_ack;
  logic o_pkt_rd;
  logic [4:0] o_pkt_idx;
  logic [2:0] o_phase;
  logic [3:0] o_ctl;
  logic o_data_en;
  modport master (output i_hcount, i_vcount, i_island_en, i_pkt_valid,
                  input o_pkt_ack, o_pkt_rd, o_pkt_idx, o_phase, o_ctl, o_data_en);
  modport slave (input i_hcount, i_vcount, i_island_en, i_pkt_valid,
                 output o_pkt_ack, o_pkt_rd, o_pkt_idx, o_phase, o_ctl, o_data_en);
endinterface

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: per-pixel choice of HDMI period (control, video, data island)
module hdmi_period_scheduler #(
  parameter int HA = 640,
  parameter int HTOTAL = 800,
  parameter int VA = 480,
  parameter int VTOTAL = 525,
  parameter int ISL_OFFSET = 4
) (
  input logic clk,
  input logic rstn,
  hdmi_period_scheduler_if.slave bus
);
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  typedef enum logic [2:0] {CTRL, VID_PRE, VID_GB, VIDEO, DI_PRE, DI_LGB, DI_PKT, DI_TGB} phase_t;
  typedef enum logic [2:0] {IDLE, PRE, LGB, PKT, TGB} isl_t;
  if (HA + ISL_OFFSET + 44 + 12 > HTOTAL - 10) begin : g_chk
    $error("island window overlaps the video preamble");
  end
  isl_t state, nxt;
  logic [4:0] cnt, nxt_cnt;
  phase_t vid, ph_d;
  logic next_active, start, last;
  // video decode, island start/advance and the phase to register next
  always_comb begin
    next_active = bus.i_vcount == VW'(VTOTAL - 1) || bus.i_vcount < VW'(VA - 1);
    vid = (bus.i_hcount < HW'(HA) && bus.i_vcount < VW'(VA)) ? VIDEO :
          (next_active && bus.i_hcount >= HW'(HTOTAL - 10) && bus.i_hcount <= HW'(HTOTAL - 3)) ? VID_PRE :
          (next_active && bus.i_hcount >= HW'(HTOTAL - 2)) ? VID_GB : CTRL;
    start = state == IDLE && bus.i_hcount == HW'(HA + ISL_OFFSET) && bus.i_island_en && bus.i_pkt_valid;
    last = cnt == (state == PRE ? 5'd7 : state == PKT ? 5'd31 : 5'd1);
    nxt = state == IDLE ? (start ? PRE : IDLE) :
          !last ? state :
          state == PRE ? LGB :
          state == LGB ? PKT :
          state == PKT ? TGB : IDLE;
    nxt_cnt = (nxt != state || state == IDLE) ? 5'd0 : cnt + 5'd1;
    ph_d = nxt == PRE ? DI_PRE :
           nxt == LGB ? DI_LGB :
           nxt == PKT ? DI_PKT :
           nxt == TGB ? DI_TGB : vid;
  end
  // island state and per-state cycle counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
    end
  end
  // registered encoder-facing outputs, one cycle behind the counts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_phase <= CTRL;
      bus.o_ctl <= '0;
      bus.o_data_en <= 1'b0;
      bus.o_pkt_ack <= 1'b0;
      bus.o_pkt_rd <= 1'b0;
      bus.o_pkt_idx <= '0;
    end else begin
      bus.o_phase <= ph_d;
      bus.o_ctl <= ph_d == VID_PRE ? 4'b0001 : ph_d == DI_PRE ? 4'b0101 : 4'b0000;
      bus.o_data_en <= ph_d == VIDEO;
      bus.o_pkt_ack <= start;
      bus.o_pkt_rd <= nxt == PKT;
      bus.o_pkt_idx <= nxt == PKT ? nxt_cnt : 5'd0;
    end
  end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: directed line-by-line check of the period scheduler
module tb_hdmi_period_scheduler;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  hdmi_period_scheduler_if #(.HTOTAL(800), .VTOTAL(525)) bus ();
  hdmi_period_scheduler dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  logic [14:0] obs;
  assign obs = {bus.o_phase, bus.o_ctl, bus.o_data_en, bus.o_pkt_ack, bus.o_pkt_rd, bus.o_pkt_idx};
  function automatic logic [14:0] expv(int h, int v, bit isl);
    logic [2:0] ph;
    logic [4:0] idx;
    bit na;
    na = v == 524 || v < 479;
    idx = 5'd0;
    if (isl && h >= 644 && h <= 687) begin
      ph = h < 652 ? 3'd4 : h < 654 ? 3'd5 : h < 686 ? 3'd6 : 3'd7;
      if (ph == 3'd6) idx = 5'(h - 654);
    end else begin
      ph = (h < 640 && v < 480) ? 3'd3 :
           (na && h >= 790 && h <= 797) ? 3'd1 :
           (na && h >= 798) ? 3'd2 : 3'd0;
    end
    return {ph, ph == 3'd1 ? 4'b0001 : ph == 3'd4 ? 4'b0101 : 4'b0000,
            ph == 3'd3, isl && h == 644, ph == 3'd6, idx};
  endfunction
  task automatic chk(string tag, logic [14:0] got, logic [14:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic step(int h, int v);
    bus.i_hcount = 10'(h);
    bus.i_vcount = 10'(v);
    @(posedge clk);
    #1;
  endtask
  task automatic run_line(int v, bit isl, int vr_h, int drop_h, int rst_h);
    for (int h = 0; h < 800; h++) begin
      if (h == vr_h) bus.i_pkt_valid = 1'b1;
      if (h == drop_h) bus.i_island_en = 1'b0;
      step(h, v);
      chk($sformatf("v%0d_h%0d", v, h), obs, expv(h, v, isl && !(rst_h >= 0 && h > rst_h)));
      if (h == rst_h) begin
        rstn = 1'b0;
        #1;
        chk($sformatf("async_rst_v%0d_h%0d", v, h), obs, 15'd0);
        #1;
        rstn = 1'b1;
      end
    end
  endtask
  initial begin
    bus.i_island_en = 1'b0;
    bus.i_pkt_valid = 1'b0;
    step(644, 0);
    chk("reset_hold", obs, 15'd0);
    step(0, 0);
    rstn = 1'b1;
    run_line(478, 1'b0, -1, -1, -1);
    run_line(479, 1'b0, -1, -1, -1);
    run_line(480, 1'b0, -1, -1, -1);
    run_line(524, 1'b0, -1, -1, -1);
    bus.i_island_en = 1'b1;
    bus.i_pkt_valid = 1'b1;
    run_line(0, 1'b1, -1, -1, -1);
    run_line(1, 1'b1, -1, -1, -1);
    bus.i_pkt_valid = 1'b0;
    run_line(2, 1'b0, 650, -1, -1);
    run_line(3, 1'b1, -1, -1, -1);
    run_line(4, 1'b1, -1, 664, -1);
    run_line(5, 1'b0, -1, -1, -1);
    run_line(6, 1'b0, -1, -1, -1);
    bus.i_island_en = 1'b1;
    run_line(500, 1'b1, -1, -1, -1);
    run_line(10, 1'b1, -1, -1, 660);
    run_line(11, 1'b1, -1, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
